// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: on start, emits cfg_num packets of cfg_len beats of incrementing data.
// Optional idle gap between packets; all outputs come straight from flops.
module axis_pkt_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [CNT_WIDTH-1:0]  cfg_num,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    output logic                  busy,
    output logic                  done,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tkeep,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] data, data_n;
    logic [LEN_WIDTH-1:0]  len, len_n, beat, beat_n;
    logic [CNT_WIDTH-1:0]  num, num_n, pkt, pkt_n;
    logic [GW-1:0]         gap_cnt, gap_n;
    logic                  valid_q, last_q, busy_q, done_q;
    logic                  valid_n, last_n, busy_n, done_n;
    logic                  xfer;

    assign xfer = valid_q & m_axis_tready;

    always_comb begin
        state_n = state;
        data_n  = data;
        len_n   = len;
        num_n   = num;
        beat_n  = beat;
        pkt_n   = pkt;
        gap_n   = gap_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    len_n  = cfg_len;
                    num_n  = cfg_num;
                    data_n = cfg_seed;
                    beat_n = '0;
                    pkt_n  = '0;
                    state_n = (cfg_len == '0 || cfg_num == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    data_n = data + DATA_WIDTH'(1);
                    if (beat == len - LEN_WIDTH'(1)) begin
                        beat_n = '0;
                        pkt_n  = pkt + CNT_WIDTH'(1);
                        gap_n  = '0;
                        if (pkt == num - CNT_WIDTH'(1)) begin
                            state_n = DONE;
                        end else if (GAP_CYCLES > 0) begin
                            state_n = GAP;
                        end
                    end else begin
                        beat_n = beat + LEN_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = SEND;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Output flags are decoded from next-state values so they register alongside the state.
        valid_n = (state_n == SEND);
        last_n  = (state_n == SEND) && (beat_n == len_n - LEN_WIDTH'(1));
        busy_n  = (state_n == SEND) || (state_n == GAP);
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            data    <= '0;
            len     <= '0;
            num     <= '0;
            beat    <= '0;
            pkt     <= '0;
            gap_cnt <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            data    <= data_n;
            len     <= len_n;
            num     <= num_n;
            beat    <= beat_n;
            pkt     <= pkt_n;
            gap_cnt <= gap_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign m_axis_tvalid = valid_q;
    assign m_axis_tkeep  = valid_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tdata  = data;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: queue model of the expected beat stream plus directed literal checks.
module tb_axis_pkt_gen;

    logic       aclk = 1'b0;
    logic       areset, start;
    logic [7:0] cfg_len, cfg_num, cfg_seed;
    logic       busy, done, tvalid, tkeep, tlast;
    logic       tready = 1'b1;
    logic [7:0] tdata;

    axis_pkt_gen #(.DATA_WIDTH(8), .LEN_WIDTH(8), .CNT_WIDTH(8), .GAP_CYCLES(2)) dut (
        .aclk(aclk), .areset(areset), .start(start),
        .cfg_len(cfg_len), .cfg_num(cfg_num), .cfg_seed(cfg_seed),
        .busy(busy), .done(done),
        .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
        .m_axis_tlast(tlast), .m_axis_tready(tready)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;
    int rmode = 0, start_cyc = 0, done_cyc = -1;
    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    logic [7:0] seen_d[$];
    logic       seen_l[$];
    int         seen_c[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected run: len*num beats seed+k, tlast every len beats.
    task automatic push_run(input logic [7:0] seed, input int len, input int num);
        for (int k = 0; k < len * num; k++) begin
            exp_q.push_back(8'(int'(seed) + k));
            exp_last_q.push_back((k % len) == len - 1);
        end
    endtask

    task automatic clear_seen();
        seen_d.delete(); seen_l.delete(); seen_c.delete();
        done_cyc = -1;
    endtask

    // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
    always @(posedge aclk) begin
        #1;
        case (rmode)
            1:       tready = ~tready;
            2:       tready = 1'($urandom_range(0, 1));
            default: tready = 1'b1;
        endcase
    end

    logic       stall_prev = 1'b0, pl;
    logic [7:0] pd, e;
    logic       el;
    always @(negedge aclk) begin
        if (!areset) begin
            if (stall_prev) begin
                chk("stall_valid", 32'(tvalid), 32'd1);
                chk("stall_data", 32'(tdata), 32'(pd));
                chk("stall_last", 32'(tlast), 32'(pl));
            end
            chk("tkeep", 32'(tkeep), 32'(tvalid));
            if (done) done_cyc = cyc;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", tdata);
                end else begin
                    e  = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    chk("beat_data", 32'(tdata), 32'(e));
                    chk("beat_last", 32'(tlast), 32'(el));
                end
                seen_d.push_back(tdata);
                seen_l.push_back(tlast);
                seen_c.push_back(cyc);
            end
            stall_prev = tvalid && !tready;
            pd = tdata;
            pl = tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic do_start(input logic [7:0] seed, input int len, input int num);
        push_run(seed, len, num);
        cfg_seed = seed;
        cfg_len  = 8'(len);
        cfg_num  = 8'(num);
        start    = 1'b1;
        @(posedge aclk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        cfg_seed  = 8'($urandom);
        cfg_len   = 8'($urandom);
        cfg_num   = 8'($urandom);
        chk("busy_after_start", 32'(busy), 32'(len != 0 && num != 0));
        chk("tvalid_after_start", 32'(tvalid), 32'(len != 0 && num != 0));
    endtask

    task automatic wait_done(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge aclk); #1;
        end
        chk("done_seen", 32'(got), 32'd1);
        @(posedge aclk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int ones;
        logic got;
        areset = 1'b1; start = 1'b0;
        cfg_len = '0; cfg_num = '0; cfg_seed = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;

        // Single packet, always ready
        clear_seen(); rmode = 0;
        do_start(8'h10, 4, 1);
        wait_done(50);
        chk("t1_count", 32'(seen_d.size()), 32'd4);
        chk("t1_first", 32'(seen_d[0]), 32'h10);
        chk("t1_lastdata", 32'(seen_d[3]), 32'h13);
        chk("t1_tlast3", 32'(seen_l[3]), 32'd1);
        chk("t1_tlast2", 32'(seen_l[2]), 32'd0);
        chk("t1_first_cyc", 32'(seen_c[0] - start_cyc), 32'd0);
        chk("t1_last_cyc", 32'(seen_c[3] - start_cyc), 32'd3);
        chk("t1_done_cyc", 32'(done_cyc - start_cyc), 32'd4);

        // Three packets with inter-packet gap
        clear_seen();
        do_start(8'h00, 3, 3);
        wait_done(100);
        chk("t2_count", 32'(seen_d.size()), 32'd9);
        chk("t2_lastdata", 32'(seen_d[8]), 32'h08);
        chk("t2_tlast2", 32'(seen_l[2]), 32'd1);
        chk("t2_tlast5", 32'(seen_l[5]), 32'd1);
        chk("t2_tlast8", 32'(seen_l[8]), 32'd1);
        chk("t2_b2b", 32'(seen_c[1] - seen_c[0]), 32'd1);
        chk("t2_gap1", 32'(seen_c[3] - seen_c[2]), 32'd3);
        chk("t2_gap2", 32'(seen_c[6] - seen_c[5]), 32'd3);

        // Toggling ready, plus a start request mid-run that must be ignored
        clear_seen(); rmode = 1;
        do_start(8'h20, 5, 2);
        repeat (3) @(posedge aclk);
        #1;
        cfg_seed = 8'hA0; cfg_len = 8'd2; cfg_num = 8'd2; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        wait_done(200);
        chk("t3_count", 32'(seen_d.size()), 32'd10);
        chk("t3_lastdata", 32'(seen_d[9]), 32'h29);

        // Data wrap
        clear_seen(); rmode = 0;
        do_start(8'hFE, 4, 1);
        wait_done(50);
        chk("t4_b1", 32'(seen_d[1]), 32'hFF);
        chk("t4_b2", 32'(seen_d[2]), 32'h00);
        chk("t4_b3", 32'(seen_d[3]), 32'h01);
        chk("t4_tlast3", 32'(seen_l[3]), 32'd1);

        // Zero-length run: no beats, done right after acceptance
        clear_seen();
        do_start(8'h55, 0, 3);
        wait_done(10);
        chk("t5a_nobeats", 32'(seen_d.size()), 32'd0);
        chk("t5a_done_cyc", 32'(done_cyc - start_cyc), 32'd0);

        // Single-beat packets: every beat is last
        clear_seen();
        do_start(8'h70, 1, 4);
        wait_done(100);
        ones = 0;
        foreach (seen_l[i]) ones += int'(seen_l[i]);
        chk("t5b_count", 32'(seen_d.size()), 32'd4);
        chk("t5b_all_last", 32'(ones), 32'd4);

        // Reset during packet 2, then fresh run from seed 0
        clear_seen();
        do_start(8'h00, 8, 4);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (seen_d.size() >= 10) begin
                got = 1'b1;
                break;
            end
            @(posedge aclk); #1;
        end
        chk("t6_reached_mid", 32'(got), 32'd1);
        areset = 1'b1;
        @(posedge aclk); #1;
        chk("t6_tvalid", 32'(tvalid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_tdata", 32'(tdata), 32'd0);
        areset = 1'b0;
        exp_q.delete(); exp_last_q.delete();
        clear_seen();
        @(posedge aclk); #1;
        do_start(8'h00, 3, 2);
        wait_done(100);
        chk("t6_count", 32'(seen_d.size()), 32'd6);
        chk("t6_first", 32'(seen_d[0]), 32'h00);

        // Start held high: back-to-back runs
        clear_seen();
        push_run(8'h40, 2, 1);
        push_run(8'h40, 2, 1);
        cfg_seed = 8'h40; cfg_len = 8'd2; cfg_num = 8'd1; start = 1'b1;
        for (int n = 0; n < 2; n++) begin
            got = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(posedge aclk); #1;
                if (done) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("t7_done", 32'(got), 32'd1);
        end
        start = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("t7_idle_busy", 32'(busy), 32'd0);
        chk("t7_idle_tvalid", 32'(tvalid), 32'd0);
        chk("t7_count", 32'(seen_d.size()), 32'd4);
        chk("t7_queue", 32'(exp_q.size()), 32'd0);

        // Random backpressure
        clear_seen(); rmode = 2;
        do_start(8'h33, 6, 3);
        wait_done(500);
        chk("t8_count", 32'(seen_d.size()), 32'd18);
        rmode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
